// File: rtl/fetch_predict.sv
// fetch_predict: program counter register with a direct-mapped branch target
// buffer (BTB) and 2-bit saturating direction counters. The lookup is
// combinational on the current PC. Each resolved branch trains the BTB at the
// rising edge.
module fetch_predict #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned BTB_IDX  = 3
) (
    input  logic        clk,
    input  logic        rst_n,        // synchronous, active-high reset
    input  logic        PCWrite,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        branch_taken,
    output logic [31:0] pred_target
);

    localparam int unsigned ENTRIES = 1 << BTB_IDX;
    localparam int unsigned TAG_W   = 32 - BTB_IDX - 2;

    logic [31:0]        pc_q;
    logic [31:0]        pc_d;

    logic               valid_q  [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic [BTB_IDX-1:0] rd_idx;
    logic [TAG_W-1:0]   rd_tag;
    logic               rd_hit;

    logic [BTB_IDX-1:0] up_idx;
    logic [TAG_W-1:0]   up_tag;
    logic               up_hit;
    logic [1:0]         up_ctr_d;

    assign PC      = pc_q;
    assign PCPlus4 = pc_q + 32'd4;

    // Combinational BTB lookup on the current fetch address
    always_comb begin
        rd_idx       = pc_q[BTB_IDX+1:2];
        rd_tag       = pc_q[31:BTB_IDX+2];
        rd_hit       = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
        branch_taken = rd_hit && ctr_q[rd_idx][1];
        pred_target  = rd_hit ? target_q[rd_idx] : '0;
    end

    // Next fetch address: redirect, then stall, then prediction, then sequential
    always_comb begin
        pc_d = PCPlus4;
        if (redirect) begin
            pc_d = redirect_pc;
        end else if (!PCWrite) begin
            pc_d = pc_q;
        end else if (branch_taken) begin
            pc_d = pred_target;
        end
    end

    // Update-side tag check and saturating counter step
    always_comb begin
        up_idx   = upd_pc[BTB_IDX+1:2];
        up_tag   = upd_pc[31:BTB_IDX+2];
        up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        up_ctr_d = ctr_q[up_idx];
        if (upd_taken) begin
            if (ctr_q[up_idx] != 2'b11) up_ctr_d = ctr_q[up_idx] + 2'd1;
        end else begin
            if (ctr_q[up_idx] != 2'b00) up_ctr_d = ctr_q[up_idx] - 2'd1;
        end
    end

    // PC register
    always_ff @(posedge clk) begin
        if (rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // BTB storage: reset clears every entry, otherwise train on resolved branches
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (upd_valid) begin
            if (up_hit) begin
                ctr_q[up_idx] <= up_ctr_d;
                if (upd_taken) target_q[up_idx] <= upd_target;
            end else if (upd_taken) begin
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= upd_target;
                ctr_q[up_idx]    <= 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_fetch_predict.sv
// Testbench for fetch_predict: a cycle-level reference model of the fetch PC
// and BTB checked against the DUT on every falling edge, plus directed
// literal expectations at key points of the scenario.
module tb_fetch_predict;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        PCWrite = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        branch_taken;
    logic [31:0] pred_target;

    int compared   = 0;
    int mismatched = 0;

    fetch_predict #(.RESET_PC(32'h0000_0000), .BTB_IDX(3)) dut (
        .clk(clk), .rst_n(rst_n), .PCWrite(PCWrite),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .PC(PC), .PCPlus4(PCPlus4),
        .branch_taken(branch_taken), .pred_target(pred_target)
    );

    always #5 clk = ~clk;

    // Reference model: 8 slots, each remembers the full branch address it was
    // trained on; tag match means same address bits above the 8-slot window.
    int unsigned m_pc;
    bit          m_v   [8];
    int unsigned m_bpc [8];
    int unsigned m_tgt [8];
    int          m_ctr [8];
    bit          m_live = 1'b0;

    function automatic int unsigned slot(input int unsigned a);
        return (a / 4) % 8;
    endfunction

    function automatic bit m_hit(input int unsigned a);
        return m_v[slot(a)] && ((m_bpc[slot(a)] / 32) == (a / 32));
    endfunction

    function automatic bit m_taken(input int unsigned a);
        return m_hit(a) && (m_ctr[slot(a)] >= 2);
    endfunction

    function automatic int unsigned m_ptgt(input int unsigned a);
        return m_hit(a) ? m_tgt[slot(a)] : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int unsigned nxt;
        int s;
        if (rst_n) begin
            m_pc = 0;
            for (int i = 0; i < 8; i++) begin
                m_v[i] = 0; m_bpc[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
            end
            m_live = 1'b1;
        end else begin
            if (redirect)          nxt = redirect_pc;
            else if (!PCWrite)     nxt = m_pc;
            else if (m_taken(m_pc)) nxt = m_ptgt(m_pc);
            else                   nxt = m_pc + 4;
            if (upd_valid) begin
                s = slot(upd_pc);
                if (m_hit(upd_pc)) begin
                    if (upd_taken) begin
                        m_ctr[s] = (m_ctr[s] == 3) ? 3 : m_ctr[s] + 1;
                        m_tgt[s] = upd_target;
                    end else begin
                        m_ctr[s] = (m_ctr[s] == 0) ? 0 : m_ctr[s] - 1;
                    end
                end else if (upd_taken) begin
                    m_v[s] = 1; m_bpc[s] = upd_pc; m_tgt[s] = upd_target; m_ctr[s] = 2;
                end
            end
            m_pc = nxt;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (m_live) begin
            chk("cyc_pc",      PC,           m_pc);
            chk("cyc_pcplus4", PCPlus4,      m_pc + 32'd4);
            chk("cyc_taken",   {31'd0, branch_taken}, {31'd0, m_taken(m_pc)});
            chk("cyc_target",  pred_target,  m_ptgt(m_pc));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic redir(input logic [31:0] a);
        redirect = 1'b1; redirect_pc = a;
        tick();
        redirect = 1'b0;
    endtask

    task automatic upd(input logic [31:0] a, input logic t, input logic [31:0] tg);
        upd_valid = 1'b1; upd_pc = a; upd_taken = t; upd_target = tg;
        tick();
        upd_valid = 1'b0;
    endtask

    initial begin
        // reset
        rst_n = 1'b1;
        tick(); tick();
        chk("rst_pc", PC, 32'h0);
        chk("rst_pcplus4", PCPlus4, 32'h4);
        chk("rst_taken", {31'd0, branch_taken}, 32'h0);
        chk("rst_target", pred_target, 32'h0);
        rst_n = 1'b0;

        // sequential fetch and stall
        PCWrite = 1'b1;
        tick(); chk("seq_4", PC, 32'h4);
        tick(); chk("seq_8", PC, 32'h8);
        PCWrite = 1'b0;
        tick(); tick(); chk("stall_8", PC, 32'h8);
        PCWrite = 1'b1;
        tick(); chk("seq_12", PC, 32'hC);
        tick(); chk("seq_16", PC, 32'h10);
        chk("seq_no_pred", {31'd0, branch_taken}, 32'h0);

        // stall plus redirect
        PCWrite = 1'b0;
        redir(32'h40); chk("stall_redirect", PC, 32'h40);
        PCWrite = 1'b1;

        // allocate at 0x10 and follow the prediction
        upd(32'h10, 1'b1, 32'h80);
        redir(32'h10);
        chk("alloc_taken", {31'd0, branch_taken}, 32'h1);
        chk("alloc_target", pred_target, 32'h80);
        tick(); chk("alloc_follow", PC, 32'h80);

        // saturation: ctr 2 -> 3,3,3 -> 2 (still taken)
        PCWrite = 1'b0;
        upd(32'h10, 1'b1, 32'h80);
        upd(32'h10, 1'b1, 32'h80);
        upd(32'h10, 1'b1, 32'h80);
        upd(32'h10, 1'b0, 32'h0);
        redir(32'h10);
        chk("sat_still_taken", {31'd0, branch_taken}, 32'h1);
        // same-cycle not-taken update: this cycle sees the old counter
        upd_valid = 1'b1; upd_pc = 32'h10; upd_taken = 1'b0; upd_target = '0;
        #1 chk("same_cycle_old", {31'd0, branch_taken}, 32'h1);
        tick(); upd_valid = 1'b0;
        chk("sat_now_not_taken", {31'd0, branch_taken}, 32'h0);
        chk("sat_target_kept", pred_target, 32'h80);

        // alias at 0x30 (same slot, different tag)
        redir(32'h30);
        chk("alias_miss_taken", {31'd0, branch_taken}, 32'h0);
        chk("alias_miss_target", pred_target, 32'h0);
        upd(32'h30, 1'b0, 32'h0);
        redir(32'h10);
        chk("alias_entry_intact", pred_target, 32'h80);
        upd(32'h10, 1'b1, 32'h90);
        chk("retrain_taken", {31'd0, branch_taken}, 32'h1);
        chk("retrain_target", pred_target, 32'h90);
        upd(32'h30, 1'b1, 32'h100);
        chk("replaced_old_miss", pred_target, 32'h0);
        redir(32'h30);
        chk("replace_taken", {31'd0, branch_taken}, 32'h1);
        chk("replace_target", pred_target, 32'h100);

        // wrap-around
        PCWrite = 1'b1;
        redir(32'hFFFF_FFFC);
        chk("wrap_pcplus4", PCPlus4, 32'h0);
        tick(); chk("wrap_pc", PC, 32'h0);

        // mid-run reset with concurrent redirect and update discarded
        rst_n = 1'b1;
        redirect = 1'b1; redirect_pc = 32'h30;
        upd_valid = 1'b1; upd_pc = 32'h20; upd_taken = 1'b1; upd_target = 32'h200;
        tick();
        redirect = 1'b0; upd_valid = 1'b0;
        chk("midrst_pc", PC, 32'h0);
        chk("midrst_taken", {31'd0, branch_taken}, 32'h0);
        rst_n = 1'b0;
        PCWrite = 1'b0;
        redir(32'h30);
        chk("midrst_miss_30", pred_target, 32'h0);
        chk("midrst_nt_30", {31'd0, branch_taken}, 32'h0);
        redir(32'h20);
        chk("midrst_miss_20", pred_target, 32'h0);
        tick();

        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
